// File: rtl/qspi_flash_reader_p.sv
// Quad I/O (0xEB) flash line reader with optional continuous-read (XIP) mode.
// Fetches one LINE_BYTES cache line per accepted request and holds it until the next done.
module qspi_flash_reader_p #(
    parameter int LINE_BYTES   = 16,
    parameter int DUMMY_CYCLES = 4,
    parameter int CLK_DIV      = 1,
    parameter int CE_HIGH      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd,
    input  logic [23:0]             addr,
    input  logic                    xip_en,
    output logic                    busy,
    output logic                    done,
    output logic [8*LINE_BYTES-1:0] line,
    output logic                    cont_active,
    output logic                    sck,
    output logic                    ce_n,
    input  logic [3:0]              din,
    output logic [3:0]              dout,
    output logic                    douten
);

    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int DATA_START = 16 + DUMMY_CYCLES;
    localparam int END_IDX    = DATA_START + 2 * LINE_BYTES;
    localparam int IDX_W      = $clog2(END_IDX + 1);
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W      = (CE_HIGH > 1) ? $clog2(CE_HIGH) : 1;

    localparam logic [7:0]       CMD        = 8'hEB;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(END_IDX - 1);
    localparam logic [IDX_W-1:0] DATA_IDX   = IDX_W'(DATA_START);
    localparam logic [IDX_W-1:0] CONT_START = IDX_W'(8);
    localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(CE_HIGH - 1);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        start_idx;
    logic [DIV_W-1:0]        div_cnt;
    logic [GAP_W-1:0]        gap_cnt;
    logic [23:0]             addr_l;
    logic [23:0]             addr_aligned;
    logic                    xip_l;
    logic [8*LINE_BYTES-1:0] line_buf;
    logic [8*LINE_BYTES-1:0] line_swapped;
    logic                    accept, tick, rise, fall, last, data_cyc;
    logic                    addr_unused;

    // idx walks one unified phase list; continuous mode simply starts it past the command byte.
    function automatic logic [4:0] pad_drive(input logic [IDX_W-1:0] i,
                                             input logic [23:0] a, input logic x);
        int          n;
        logic [2:0]  bsel;
        logic [23:0] sh;
        n    = int'(i);
        bsel = 3'(7 - n);
        sh   = a >> (4 * (13 - n));
        if (n < 8)  return {4'b1110, CMD[bsel]};
        if (n < 14) return {1'b1, sh[3:0]};
        if (n < 16) return {1'b1, x ? ((n == 14) ? 4'hA : 4'h0) : 4'hF};
        return 5'b0_0000;
    endfunction

    assign addr_unused  = ^addr[OFF_W-1:0];
    assign addr_aligned = {addr[23:OFF_W], OFF_W'(0)};
    assign start_idx    = cont_active ? CONT_START : '0;
    assign accept       = (state == IDLE) && rd && !rst;
    assign tick         = (state == XFER) && (div_cnt == DIV_MAX);
    assign rise         = tick && !sck;
    assign fall         = tick && sck;
    assign last         = fall && (idx == LAST_IDX);
    assign data_cyc     = (idx >= DATA_IDX);
    assign busy         = (state != IDLE);

    // Nibbles are shifted in low-nibble-first per byte; swap back to high-nibble-first.
    always_comb begin
        line_swapped = '0;
        for (int i = 0; i < LINE_BYTES; i++)
            line_swapped[8*i +: 8] = {line_buf[8*i +: 4], line_buf[8*i+4 +: 4]};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = XFER;
            XFER:    if (last) state_next = GAP;
            GAP:     if (gap_cnt == GAP_MAX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck         <= 1'b0;
            ce_n        <= 1'b1;
            done        <= 1'b0;
            cont_active <= 1'b0;
            douten      <= 1'b1;
            dout        <= 4'b1100;
            div_cnt     <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                ce_n             <= 1'b0;
                sck              <= 1'b0;
                div_cnt          <= '0;
                idx              <= start_idx;
                {douten, dout}   <= pad_drive(start_idx, addr_aligned, xip_en);
            end else if (state == XFER) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (rise) sck <= 1'b1;
                if (fall) begin
                    sck <= 1'b0;
                    if (last) begin
                        ce_n           <= 1'b1;
                        done           <= 1'b1;
                        cont_active    <= xip_l;
                        {douten, dout} <= 5'b1_1100;
                        gap_cnt        <= '0;
                    end else begin
                        idx            <= idx + 1'b1;
                        {douten, dout} <= pad_drive(idx + 1'b1, addr_l, xip_l);
                    end
                end
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Data path: latched request, capture buffer and the visible line.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_l <= addr_aligned;
            xip_l  <= xip_en;
        end
        if (rise && data_cyc) line_buf <= {din, line_buf[8*LINE_BYTES-1:4]};
        if (last && !rst) line <= line_swapped;
    end

endmodule

// File: tb/tb_qspi_flash_reader_p.sv
// Self-checking bench for qspi_flash_reader_p: default and small-line instances behind a shared bus,
// a behavioural flash model that derives the expected pad sequence and line from the phase rules.
module tb_qspi_flash_reader_p;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd = 1'b0;
    logic        xip = 1'b0;
    logic        sel = 1'b0;
    logic [23:0] addr = '0;
    logic [3:0]  din = '0;

    logic         rd0, rd1;
    logic         busy0, done0, cont0, sck0, ce0, den0;
    logic [3:0]   dout0;
    logic [127:0] line0;
    logic         busy1, done1, cont1, sck1, ce1, den1;
    logic [3:0]   dout1;
    logic [31:0]  line1;

    logic         busy_m, done_m, cont_m, sck_m, ce_m, den_m;
    logic [3:0]   dout_m;
    logic [127:0] line_m;

    assign rd0    = rd & ~sel;
    assign rd1    = rd & sel;
    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;
    assign cont_m = sel ? cont1 : cont0;
    assign sck_m  = sel ? sck1 : sck0;
    assign ce_m   = sel ? ce1 : ce0;
    assign den_m  = sel ? den1 : den0;
    assign dout_m = sel ? dout1 : dout0;
    assign line_m = sel ? {96'b0, line1} : line0;

    qspi_flash_reader_p u0 (
        .clk(clk), .rst(rst), .rd(rd0), .addr(addr), .xip_en(xip),
        .busy(busy0), .done(done0), .line(line0), .cont_active(cont0),
        .sck(sck0), .ce_n(ce0), .din(din), .dout(dout0), .douten(den0)
    );

    qspi_flash_reader_p #(.LINE_BYTES(4), .DUMMY_CYCLES(6), .CLK_DIV(3), .CE_HIGH(2)) u1 (
        .clk(clk), .rst(rst), .rd(rd1), .addr(addr), .xip_en(xip),
        .busy(busy1), .done(done1), .line(line1), .cont_active(cont1),
        .sck(sck1), .ce_n(ce1), .din(din), .dout(dout1), .douten(den1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]   mem [256];
    logic [4:0]   exp_io[$];
    logic [4:0]   exp_msk[$];
    logic [3:0]   din_q[$];
    logic [127:0] exp_line;
    int           model_cont [2];
    int           nchk = 0, nerr = 0;
    int           mon_k = 0, done_cnt = 0, e0 = 0, exp_n = 0, last_lat = 0;
    bit           mon_act = 0, prev_ce = 1, prev_sck = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic put(input logic [4:0] e, input logic [4:0] m, input logic [3:0] d);
        exp_io.push_back(e);
        exp_msk.push_back(m);
        din_q.push_back(d);
    endtask

    // Expected pad sequence per SCK cycle, the flash's data nibbles, and the resulting line.
    task automatic build(input logic [23:0] a, input bit x);
        int          dc, lb;
        logic [23:0] al, t;
        logic [7:0]  cmd, b, ix;
        dc  = sel ? 6 : 4;
        lb  = sel ? 4 : 16;
        cmd = 8'hEB;
        al  = a & ~24'(lb - 1);
        exp_io.delete(); exp_msk.delete(); din_q.delete();
        exp_line = '0;
        if (model_cont[sel] == 0)
            for (int i = 7; i >= 0; i--) put({4'b1110, cmd[i]}, 5'h1F, 4'h0);
        for (int i = 0; i < 6; i++) begin
            t = al >> (20 - 4 * i);
            put({1'b1, t[3:0]}, 5'h1F, 4'h0);
        end
        put({1'b1, x ? 4'hA : 4'hF}, 5'h1F, 4'h0);
        put({1'b1, x ? 4'h0 : 4'hF}, 5'h1F, 4'h0);
        for (int i = 0; i < dc; i++) put(5'h00, 5'h1F, 4'h0);
        for (int j = 0; j < 2 * lb; j++) begin
            ix = al[7:0] + 8'(j / 2);
            b  = mem[ix];
            put(5'h00, 5'h10, (j % 2 == 0) ? b[7:4] : b[3:0]);
        end
        for (int i = 0; i < lb; i++) begin
            ix = al[7:0] + 8'(i);
            exp_line[8*i +: 8] = mem[ix];
        end
        exp_n = exp_io.size();
    endtask

    // Flash side: present data on each SCK fall, check the pads on each SCK rise.
    always @(posedge clk) begin
        #1;
        if (prev_ce && !ce_m) begin
            mon_act = 1;
            mon_k   = 0;
            din     = (din_q.size() > 0) ? din_q[0] : 4'h0;
        end else if (!prev_ce && ce_m) begin
            mon_act = 0;
        end
        if (mon_act && !prev_sck && sck_m) begin
            if (mon_k < exp_io.size())
                check($sformatf("io%0d", mon_k), {den_m, dout_m} & exp_msk[mon_k],
                      exp_io[mon_k] & exp_msk[mon_k]);
            else
                check("io_extra", mon_k, exp_io.size());
            mon_k++;
            din = (mon_k < din_q.size()) ? din_q[mon_k] : 4'h0;
        end
        if (done_m) done_cnt++;
        prev_ce  = ce_m;
        prev_sck = sck_m;
    end

    task automatic start_read(input logic [23:0] a, input bit x);
        int w;
        w = 0;
        while (busy_m && w < 1000) begin
            @(posedge clk); #1;
            w++;
        end
        if (busy_m) check("busy_wait", 1, 0);
        build(a, x);
        addr = a;
        xip  = x;
        rd   = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        e0 = cyc;
        check("acc_busy", busy_m, 1);
        check("acc_ce_n", ce_m, 0);
        check("acc_sck", sck_m, 0);
        check("acc_pad", {den_m, dout_m}, exp_io[0]);
    endtask

    task automatic finish_read(input bit spam, input bit x);
        int w, d0, dv;
        dv = sel ? 3 : 1;
        d0 = done_cnt;
        w  = 0;
        while (!done_m && w < 4000) begin
            rd = (spam && busy_m) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            w++;
        end
        if (!done_m) begin
            rd = 1'b0;
            check("done_timeout", 0, 1);
            return;
        end
        last_lat = cyc - e0;
        check("latency", last_lat, 2 * dv * exp_n);
        check("sck_cycles", mon_k, exp_n);
        check("line", line_m, exp_line);
        check("cont_at_done", cont_m, x);
        check("done_ce_n", ce_m, 1);
        check("done_sck", sck_m, 0);
        check("done_douten", den_m, 1);
        model_cont[sel] = x;
        rd = spam ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int g = 1; g <= 2; g++) begin
            @(posedge clk); #1;
            if (g == 1) check("done_clear", done_m, 0);
            check($sformatf("busy_gap%0d", g), busy_m, (g < 2));
            rd = (spam && busy_m) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        rd = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("done_count", done_cnt - d0, 1);
        check("line_hold", line_m, exp_line);
    endtask

    task automatic read(input logic [23:0] a, input bit x, input bit spam);
        start_read(a, x);
        finish_read(spam, x);
    endtask

    function automatic logic [23:0] rnd_addr();
        return 24'($urandom_range(0, 32'h00FF_FFFF));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] saved;
        int dcnt, w;
        model_cont[0] = 0;
        model_cont[1] = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) mem[8'h40 + i] = 8'(i);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #0;
            check("rst_ce_n", ce_m, 1);
            check("rst_sck", sck_m, 0);
            check("rst_busy", busy_m, 0);
            check("rst_done", done_m, 0);
            check("rst_cont", cont_m, 0);
            check("rst_pads", {den_m, dout_m}, 5'b1_1100);
        end
        sel = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        read(24'h012345, 1'b0, 1'b0);
        check("lat_default", last_lat, 104);
        check("line_incr", line_m, 128'h0f0e0d0c0b0a09080706050403020100);
        check("cont_stays0", cont_m, 0);

        read(24'h000100, 1'b1, 1'b0);
        check("lat_xip_first", last_lat, 104);
        read(24'h000200, 1'b1, 1'b0);
        check("lat_xip_cont", last_lat, 88);

        read(rnd_addr(), 1'b0, 1'b0);
        check("lat_xip_exit", last_lat, 88);
        read(rnd_addr(), 1'b0, 1'b0);
        check("lat_after_exit", last_lat, 104);

        for (int i = 0; i < 6; i++) read(rnd_addr(), 1'($urandom_range(0, 1)), 1'b1);

        read(rnd_addr(), 1'b1, 1'b0);
        saved = line_m;
        dcnt  = done_cnt;
        start_read(rnd_addr(), 1'b1);
        w = 0;
        while (mon_k < 20 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        check("rst_reach_sck20", (mon_k >= 20), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_ce_n", ce_m, 1);
        check("mid_rst_sck", sck_m, 0);
        check("mid_rst_busy", busy_m, 0);
        check("mid_rst_cont", cont_m, 0);
        check("mid_rst_done", done_m, 0);
        check("mid_rst_pads", {den_m, dout_m}, 5'b1_1100);
        model_cont[0] = 0;
        model_cont[1] = 0;
        repeat (150) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - dcnt, 0);
        check("mid_rst_line", line_m, saved);
        read(rnd_addr(), 1'b0, 1'b0);
        check("lat_after_rst", last_lat, 104);

        sel = 1'b1;
        @(posedge clk); #1;
        read(rnd_addr(), 1'b0, 1'b0);
        check("lat_small", last_lat, 180);
        read(rnd_addr(), 1'b1, 1'b1);
        read(rnd_addr(), 1'b1, 1'b1);
        check("lat_small_cont", last_lat, 132);
        read(rnd_addr(), 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
